vector_checker: RTL and testbench

VECTOR_CHECKER -- requirements
Module: vector_checker

---
 rtl/vec_chk_pkg.sv | 14 +
 rtl/vector_checker_vec_mem.sv | 33 +++
 rtl/vector_checker.sv | 121 ++++++++++++
 tb/tb_vector_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_chk_pkg.sv
// Shared FSM encoding and parameter defaults for the vector checker.
package vec_chk_pkg;

  localparam int unsigned NUM_VECS_DEF = 6;
  localparam int unsigned OUT_W_DEF    = 2;
  localparam int unsigned IDX_W_DEF    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vector_checker_vec_mem.sv
// Expected-vector register file: one synchronous write port, one combinational
// read port, deliberately not reset so contents survive a checker reset.
module vec_mem #(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned W     = 2,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port; out-of-range reads return zero.
  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < DEPTH) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/vector_checker.sv
// Compares a stream of observed DUT words against a loaded table of expected
// words, counting mismatches and reporting pass/fail at the end of a run.
module vector_checker
  import vec_chk_pkg::*;
#(
  parameter int unsigned NUM_VECS = NUM_VECS_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_addr,
  input  logic [OUT_W-1:0] load_data,
  input  logic             start,
  input  logic             obs_valid,
  input  logic [OUT_W-1:0] obs_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [IDX_W:0]   err_count,
  output logic [IDX_W-1:0] first_fail
);

  localparam int unsigned CNT_W = IDX_W + 1;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   err_count_q;
  logic [IDX_W-1:0]   first_fail_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               mismatch_q;

  logic               mem_we_c;
  logic [OUT_W-1:0]   exp_word_c;
  logic               fail_c;
  logic               last_c;

  // Table writes only outside RUN, and a simultaneous start wins over the write.
  assign mem_we_c   = load_en && !start && !rst && (state_q != RUN);
  assign fail_c     = (obs_data != exp_word_c);
  assign last_c     = (idx_q == IDX_W'(NUM_VECS - 1));

  vec_mem #(
    .DEPTH (NUM_VECS),
    .W     (OUT_W),
    .AW    (IDX_W)
  ) u_vec_mem (
    .clk     (clk),
    .we_i    (mem_we_c),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (idx_q),
    .rdata_o (exp_word_c)
  );

  // Run-control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RUN;
            idx_q        <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        RUN: begin
          if (obs_valid) begin
            if (fail_c) begin
              mismatch_q  <= 1'b1;
              err_count_q <= err_count_q + CNT_W'(1);
              if (err_count_q == '0) begin
                first_fail_q <= idx_q;
              end
            end
            if (last_c) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_q == '0) && !fail_c;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_vector_checker.sv
// Randomized and directed bench for vector_checker with a behavioural model
// and a queue-based scoreboard for mismatch pulses and end-of-run results.
module tb_vector_checker;

  localparam int NV = 6;
  localparam int OW = 2;
  localparam int IW = 3;

  logic          clk;
  logic          rst;
  logic          load_en;
  logic [IW-1:0] load_addr;
  logic [OW-1:0] load_data;
  logic          start;
  logic          obs_valid;
  logic [OW-1:0] obs_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic          mismatch;
  logic [IW:0]   err_count;
  logic [IW-1:0] first_fail;

  vector_checker #(.NUM_VECS(NV), .OUT_W(OW), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .obs_valid  (obs_valid),
    .obs_data   (obs_data),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the checker
  logic [OW-1:0] tab [NV];
  bit m_run, m_done;
  int m_idx, m_err, m_ff;

  typedef struct { bit pass; int err; int ff; } result_t;
  bit      exp_q [$];
  result_t res_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model is advanced for the edge ahead,
  // then the registered outputs are checked on the following falling edge.
  task automatic step(input bit st, input bit ld, input int la, input int lv,
                      input bit ov, input int od, input bit r);
    bit f;
    start     = st;
    load_en   = ld;
    load_addr = IW'(la);
    load_data = OW'(lv);
    obs_valid = ov;
    obs_data  = OW'(od);
    rst       = r;
    if (r) begin
      m_run = 0; m_done = 0; m_idx = 0; m_err = 0; m_ff = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_done = 0; m_idx = 0; m_err = 0; m_ff = 0;
      end else if (ld && la < NV) begin
        tab[la] = OW'(lv);
      end
      if (ov) exp_q.push_back(1'b0);
    end else if (ov) begin
      f = (OW'(od) != tab[m_idx]);
      exp_q.push_back(f);
      if (f) begin
        if (m_err == 0) m_ff = m_idx;
        m_err++;
      end
      if (m_idx == NV - 1) begin
        m_run = 0;
        m_done = 1;
        res_q.push_back('{m_err == 0, m_err, m_ff});
      end else begin
        m_idx++;
      end
    end
    @(negedge clk);
    chk("busy", int'(busy), int'(m_run));
    chk("done", int'(done), int'(m_done));
    chk("pass", int'(pass), int'(m_done && m_err == 0));
    chk("err_count", int'(err_count), m_err);
    chk("first_fail", int'(first_fail), m_ff);
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Present a run of observations, inserting 'gap' idle cycles after each.
  task automatic run_obs(input int v0, input int v1, input int v2, input int v3,
                         input int v4, input int v5, input int gap);
    int vals [NV];
    vals = '{v0, v1, v2, v3, v4, v5};
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NV; i++) begin
      step(0, 0, 0, 0, 1, vals[i], 0);
      for (int g = 0; g < gap; g++) idle_cycle();
    end
    idle_cycle();
  endtask

  // Scoreboard monitor: mismatch pulses and end-of-run results.
  initial begin
    bit pv, pr, e, done_prev;
    result_t r;
    done_prev = 0;
    forever begin
      @(posedge clk);
      pv = obs_valid;
      pr = rst;
      @(negedge clk);
      e = 0;
      if (pv && !pr) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_underflow mismatch actual=%0d expected=none", mismatch);
        end else begin
          e = exp_q.pop_front();
        end
      end
      chk("sb_mismatch", int'(mismatch), int'(e));
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_unexpected_done actual=1 expected=0");
        end else begin
          r = res_q.pop_front();
          chk("sb_pass", int'(pass), int'(r.pass));
          chk("sb_err_count", int'(err_count), r.err);
          chk("sb_first_fail", int'(first_fail), r.ff);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int od, la;
    clk = 0;
    rst = 1; start = 0; load_en = 0; load_addr = '0; load_data = '0;
    obs_valid = 0; obs_data = '0;
    m_run = 0; m_done = 0; m_idx = 0; m_err = 0; m_ff = 0;
    for (int i = 0; i < NV; i++) tab[i] = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 3, 1);
    chk("reset_mismatch", int'(mismatch), 0);

    // Load the reference table 00,10,10,01,10,01
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 0, 0, 0);
    step(0, 1, 2, 2, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0, 0);
    step(0, 1, 4, 2, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 0);
    // obs_valid while idle is ignored
    step(0, 0, 0, 0, 1, 3, 0);

    // All-pass, back-to-back observations
    run_obs(0, 2, 2, 1, 2, 1, 0);
    // Two failures at vectors 2 and 5; start from DONE also restarts
    run_obs(0, 2, 3, 1, 2, 0, 0);
    // obs_valid in DONE is ignored
    step(0, 0, 0, 0, 1, 3, 0);
    // Gapped valid: every third cycle
    run_obs(0, 2, 2, 1, 2, 1, 2);

    // Load rules: out-of-range address, load during RUN, load with start
    step(0, 1, 7, 3, 0, 0, 0);
    step(0, 1, 6, 3, 0, 0, 0);
    step(1, 1, 1, 3, 0, 0, 0);
    step(0, 1, 0, 3, 0, 0, 0);
    for (int i = 0; i < NV; i++) step(0, (i == 2), 3, 0, 1, int'(tab[i]), 0);
    idle_cycle();
    run_obs(0, 2, 2, 1, 2, 1, 0);

    // Reset mid-run after three vectors; table must be retained
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 1, 2, 0);
    step(1, 1, 0, 3, 1, 2, 1);
    chk("midrun_reset_mismatch", int'(mismatch), 0);
    run_obs(0, 2, 2, 1, 2, 1, 0);

    // Restart straight from DONE with a failing run
    run_obs(1, 2, 2, 1, 2, 1, 0);
    run_obs(0, 2, 2, 1, 2, 1, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      la = int'($urandom_range(0, 7));
      if (m_run && ($urandom_range(0, 3) != 0)) od = int'(tab[m_idx]);
      else od = int'($urandom_range(0, 3));
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0), la,
           int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), od,
           ($urandom_range(0, 199) == 0));
    end

    idle_cycle();
    idle_cycle();
    chk("sb_exp_q_drained", exp_q.size(), 0);
    chk("sb_res_q_drained", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
